// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//
// Purpose:
//   Shares a single 23-bit adder among NUM_REQ requesters. A round-robin
//   arbiter picks one requester and captures its operands. The shared adder
//   then computes a+b, and the result is presented on a valid/ready response
//   port. At most one add is in flight at a time. Sustained throughput is one
//   add every two cycles.
//
// Optional feature:
//   ADDER_ARB_OVF_EN - when defined, adds the rsp_ovf output. This flag reports
//                      signed two's-complement overflow of the returned sum.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous, active-high reset
//   req        in   NUM_REQ        level request per requester
//   a_in       in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in       in   NUM_REQ*WIDTH  operand B, same packing
//   gnt        out  NUM_REQ        one-hot grant, one-cycle pulse
//   rsp_valid  out  1              result valid
//   rsp_ready  in   1              result consumer ready
//   rsp_id     out  ID_W           requester that owns the result
//   rsp_sum    out  WIDTH          a+b modulo 2^WIDTH
//   rsp_carry  out  1              unsigned carry-out
//   rsp_ovf    out  1              signed overflow (ADDER_ARB_OVF_EN only)
// ---------------------------------------------------------------------------

// Plain 23-bit adder with carry-out; the resource being shared.
module adder_23bit (
    input  logic [22:0] a_i,
    input  logic [22:0] b_i,
    output logic [22:0] sum_o,
    output logic        carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 23,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ_C = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_C = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]      op_id_q, op_id_d;
    logic [WIDTH-1:0]      op_a_q, op_a_d;
    logic [WIDTH-1:0]      op_b_q, op_b_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]      rsp_sum_q, rsp_sum_d;
    logic                  rsp_carry_q, rsp_carry_d;

    // Unpack the flat operand buses into per-requester arrays.
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: first asserted request at ptr, ptr+1, ... wrapping.
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   scan_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (scan_idx >= NREQ_C) begin
                scan_idx = scan_idx - NREQ_C;
            end
            if (!win_found && req[scan_idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    // The shared adder always sees the captured operands.
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    adder_23bit u_adder (
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        op_id_d     = op_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d        = S_CALC;
                    gnt_d[win_idx] = 1'b1;
                    op_id_d        = win_idx;
                    op_a_d         = a_arr[win_idx];
                    op_b_d         = b_arr[win_idx];
                    ptr_d          = (win_idx == LAST_C) ? '0 : win_idx + 1'b1;
                end
            end
            S_CALC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = ID_W'(op_id_q);
                rsp_sum_d   = add_sum;
                rsp_carry_d = add_carry;
            end
            S_RESP: begin
                // The response is held until it is accepted. Acceptance is
                // also the next arbitration point, so back-to-back adds never
                // pass through IDLE.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (win_found) begin
                        state_d        = S_CALC;
                        gnt_d[win_idx] = 1'b1;
                        op_id_d        = win_idx;
                        op_a_d         = a_arr[win_idx];
                        op_b_d         = b_arr[win_idx];
                        ptr_d          = (win_idx == LAST_C) ? '0 : win_idx + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            op_id_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            op_id_q     <= op_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    // Signed overflow: the operands share a sign and the sum's sign differs.
    // This flag is captured and held together with rsp_sum.
    logic rsp_ovf_q, rsp_ovf_d;

    always_comb begin
        rsp_ovf_d = rsp_ovf_q;
        if (state_q == S_CALC) begin
            rsp_ovf_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != op_a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    // Overflow reporting is not built; only sum and carry are returned.
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;

endmodule
